// File: rtl/temporal_min.sv
// rtl/temporal_min.sv - race-logic MIN: one registered pulse at the first arrival of a or b per gamma cycle
module temporal_min (
  input  logic aclk,
  input  logic grst,
  input  logic a,
  input  logic b,
  output logic y
);

  logic fired;
  logic y_q;
  logic hit;

  // Only the first arrival in a gamma cycle gets through; later or held events are masked.
  assign hit = (a | b) & ~fired;

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      fired <= 1'b0;
      y_q   <= 1'b0;
    end else if (hit) begin
      fired <= 1'b1;
      y_q   <= 1'b1;
    end else begin
      y_q   <= 1'b0;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_temporal_min.sv
// tb/tb_temporal_min.sv - self-checking bench for temporal_min against a first-arrival model
module tb_temporal_min;

  logic aclk = 1'b0;
  logic grst = 1'b1;
  logic a    = 1'b0;
  logic b    = 1'b0;
  logic y;

  int cyc    = 0;
  int first  = -1;
  int ycount = 0;
  int ycycle = -1;
  int checks = 0;
  int errors = 0;

  temporal_min dut (
    .aclk (aclk),
    .grst (grst),
    .a    (a),
    .b    (b),
    .y    (y)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: y is high only in the cycle right after the earliest cycle in which a or b was present.
  always @(negedge aclk) begin
    int exp_y;
    if (grst) exp_y = 0;
    else      exp_y = (first >= 0 && cyc == first + 1) ? 1 : 0;
    check("y_cycle", int'(y), exp_y);
    if (!grst && y) begin
      ycount++;
      ycycle = cyc;
    end
  end

  task automatic begin_gamma();
    grst  = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    first = -1;
    repeat (2) @(posedge aclk);
    #2;
    grst   = 1'b0;
    cyc    = 0;
    ycount = 0;
    ycycle = -1;
  endtask

  task automatic drive(input int n, input int a_on, input int a_off, input int b_on, input int b_off);
    for (int i = 0; i < n; i++) begin
      a = (cyc >= a_on && cyc <= a_off);
      b = (cyc >= b_on && cyc <= b_off);
      if ((a || b) && first < 0) first = cyc;
      @(posedge aclk);
      #2;
      cyc++;
    end
    a = 1'b0;
    b = 1'b0;
  endtask

  initial begin
    @(posedge aclk);
    #2;
    check("reset_y", int'(y), 0);

    begin_gamma();
    drive(40, -1, -1, -1, -1);
    check("no_event_count", ycount, 0);

    begin_gamma();
    drive(40, 10, 10, 20, 20);
    check("a_first_count", ycount, 1);
    check("a_first_at", ycycle, 11);

    begin_gamma();
    drive(40, 20, 20, 10, 10);
    check("b_first_count", ycount, 1);
    check("b_first_at", ycycle, 11);

    begin_gamma();
    drive(30, 10, 10, 10, 10);
    check("tie_count", ycount, 1);
    check("tie_at", ycycle, 11);

    for (int r = 0; r < 2; r++) begin
      begin_gamma();
      drive(40, 5, 30, -1, -1);
      check("held_count", ycount, 1);
      check("held_at", ycycle, 6);
    end

    begin_gamma();
    drive(10, 0, 0, -1, -1);
    check("time0_count", ycount, 1);
    check("time0_at", ycycle, 1);

    begin_gamma();
    drive(4, 3, 3, -1, -1);
    check("pre_async_y", int'(y), 1);
    #1;
    grst  = 1'b1;
    first = -1;
    #1;
    check("async_clear", int'(y), 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk);
      #2;
      a = 1'($urandom_range(1, 0));
      b = 1'(i % 2);
    end
    @(posedge aclk);
    #2;
    check("held_reset_y", int'(y), 0);

    begin_gamma();
    drive(10, 2, 2, -1, -1);
    check("after_reset_count", ycount, 1);
    check("after_reset_at", ycycle, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
